control_fsm: RTL

Multi-cycle control unit for the RV32I core. It sequences the program counter, instruction memory, register file and ALU through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select from `top`, and it waits on ready handshakes from instruction and data memory with a bounded timeout.

---
 rtl/control_fsm.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// control_fsm : multi-cycle RV32I control unit sequencing fetch, decode,
//               execute, memory and writeback, with a bounded ready timeout.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN (halt and flag illegal opcodes)
// Revision    : 1.0
// ============================================================================
module control_fsm #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       bus_err,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_LOAD_WB  = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // The counter only ever holds 0..WAIT_LIMIT-1: the wait that would make
    // it reach WAIT_LIMIT is the one that diverts to HALT instead.
    localparam int          c_CW         = (WAIT_LIMIT <= 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam int          c_LIM_M1_INT = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;
    localparam logic [c_CW-1:0] c_LIMIT_M1 = c_CW'(c_LIM_M1_INT);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
    localparam logic        c_TIMEOUT_EN = (WAIT_LIMIT != 0);

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_bus_err;
    logic              w_timeout;
    logic              w_taken;

    assign w_timeout = c_TIMEOUT_EN && (r_cnt == c_LIMIT_M1);
    assign w_taken   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal_instr = r_illegal;
`else
    assign illegal_instr = 1'b0;
`endif

    assign bus_err = r_bus_err;
    assign state   = r_state;

    // Counter defaults to clear; only the hold-and-wait branches advance it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        c_OP_R:      r_state <= S_EXEC_R;
                        c_OP_I:      r_state <= S_EXEC_I;
                        c_OP_LOAD:   r_state <= S_MEM_ADDR;
                        c_OP_STORE:  r_state <= S_MEM_ADDR;
                        c_OP_BRANCH: r_state <= S_BRANCH;
                        c_OP_JAL:    r_state <= S_JAL;
                        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            r_state   <= S_HALT;
                            r_illegal <= 1'b1;
`else
                            r_state   <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_EXEC_R:   r_state <= S_ALU_WB;
                S_EXEC_I:   r_state <= S_ALU_WB;
                S_ALU_WB:   r_state <= S_FETCH;
                S_MEM_ADDR: r_state <= (opcode == c_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD, S_MEM_WR: begin
                    if (dmem_ready) begin
                        r_state <= (r_state == S_MEM_RD) ? S_LOAD_WB : S_FETCH;
                    end else if (w_timeout) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_LOAD_WB:  r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JAL:      r_state <= S_FETCH;
                S_HALT:     r_state <= S_HALT;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; FETCH loads are gated by reset so a coinciding ready is dropped.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                imem_req  = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = imem_ready & ~reset;
                pc_write  = imem_ready & ~reset;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                dmem_req = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            S_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = w_taken;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
